mtm_alu_rx_p: RTL and testbench

MTM_ALU_RX_P -- requirements
Module: mtm_alu_rx_p

---
 rtl/mtm_alu_rx_p.sv | 146 ++++++++++++++
 tb/tb_mtm_alu_rx_p.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mtm_alu_rx_p.sv
// Serial packet receiver for the MTM ALU: collects two operands and a command, then presents them
// with error flags. Define MTM_ALU_RX_CRC_EN to build the CRC-4 check on the command packet.
module mtm_alu_rx_p #(
  parameter int OPERAND_BYTES = 4,
  parameter int W             = 8 * OPERAND_BYTES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sin,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [2:0]   op_o,
  output logic [3:0]   err_o,
  output logic         valid_o,
  input  logic         ready_i
);

  localparam int NB = 2 * OPERAND_BYTES;
  localparam int CW = $clog2(NB + 1);
  localparam logic [CW-1:0] NB_C = CW'(NB);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] TYPE    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] STOP    = 2'd3;

  logic [1:0]    state_q;
  logic [2:0]    bit_q;
  logic          type_q;
  logic [7:0]    pay_q;
  logic [CW-1:0] cnt_q;
  logic          extra_q;
  logic [2*W-1:0] ab_q;

  logic [W-1:0] a_q, b_q;
  logic [2:0]   op_q;
  logic [3:0]   err_q;
  logic         valid_q;

  logic       stop_ok, cmd_done, err_data, err_crc, load;
  logic [2:0] cmd_op;

  assign stop_ok  = (state_q == STOP) && sin;
  assign cmd_done = stop_ok && type_q;
  assign cmd_op   = pay_q[6:4];
  // Extra data packets leave the counter saturated, so they need their own sticky flag.
  assign err_data = (cnt_q != NB_C) || extra_q;
  assign load     = cmd_done && (!valid_q || ready_i);

`ifdef MTM_ALU_RX_CRC_EN
  logic [3:0] crc_q, crc_d;

  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    return {c[2:0], 1'b0} ^ ({4{c[3] ^ b}} & 4'b0011);
  endfunction

  // The CRC stream is {A, B, 1, op}; the 1 is the command type bit itself.
  always_comb begin
    crc_d = crc_q;
    unique case (state_q)
      TYPE: if (sin) crc_d = crc_step(crc_q, 1'b1);
      PAYLOAD: begin
        if (type_q ? (bit_q inside {[3'd1:3'd3]}) : (cnt_q < NB_C)) crc_d = crc_step(crc_q, sin);
      end
      STOP: if (!sin || type_q) crc_d = 4'd0;
      default: crc_d = crc_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= 4'd0;
    else        crc_q <= crc_d;
  end

  assign err_crc = (crc_q != pay_q[3:0]);
`else
  assign err_crc = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= 3'd0;
      type_q  <= 1'b0;
      pay_q   <= 8'd0;
      cnt_q   <= '0;
      extra_q <= 1'b0;
      ab_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (!sin) state_q <= TYPE;
        TYPE: begin
          type_q  <= sin;
          bit_q   <= 3'd0;
          state_q <= PAYLOAD;
        end
        PAYLOAD: begin
          pay_q <= {pay_q[6:0], sin};
          bit_q <= bit_q + 3'd1;
          if (bit_q == 3'd7) state_q <= STOP;
        end
        STOP: begin
          state_q <= IDLE;
          if (!sin || type_q) begin
            cnt_q   <= '0;
            extra_q <= 1'b0;
          end else if (cnt_q < NB_C) begin
            ab_q  <= {ab_q[2*W-9:0], pay_q};
            cnt_q <= cnt_q + 1'b1;
          end else begin
            extra_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= 3'd0;
      err_q   <= 4'd0;
      valid_q <= 1'b0;
    end else if (load) begin
      a_q     <= err_data ? '0 : ab_q[2*W-1:W];
      b_q     <= err_data ? '0 : ab_q[W-1:0];
      op_q    <= cmd_op;
      err_q   <= {1'b0, cmd_op[1], err_crc, err_data};
      valid_q <= 1'b1;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end else if (valid_q && cmd_done) begin
      // Result arrived while the previous one is still held: drop it, flag overflow.
      err_q[3] <= 1'b1;
    end
  end

  assign a_o     = a_q;
  assign b_o     = b_q;
  assign op_o    = op_q;
  assign err_o   = err_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_mtm_alu_rx_p.sv
// Scoreboard bench for mtm_alu_rx_p: OPERAND_BYTES=4 main instance plus an OPERAND_BYTES=1 instance.
module tb_mtm_alu_rx_p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        sin1 = 1'b1;
  logic        ready = 1'b1;
  logic [31:0] a_o, b_o;
  logic [2:0]  op_o;
  logic [3:0]  err_o;
  logic        valid_o;
  logic [7:0]  a1_o, b1_o;
  logic [2:0]  op1_o;
  logic [3:0]  err1_o;
  logic        valid1_o;

  int checks = 0;
  int failures = 0;

`ifdef MTM_ALU_RX_CRC_EN
  localparam logic [3:0] CRC_ERR = 4'b0010;
`else
  localparam logic [3:0] CRC_ERR = 4'b0000;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mtm_alu_rx_p #(.OPERAND_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .a_o(a_o), .b_o(b_o), .op_o(op_o),
    .err_o(err_o), .valid_o(valid_o), .ready_i(ready)
  );

  mtm_alu_rx_p #(.OPERAND_BYTES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sin(sin1), .a_o(a1_o), .b_o(b1_o), .op_o(op1_o),
    .err_o(err1_o), .valid_o(valid1_o), .ready_i(ready)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // CRC-4 (x^4+x+1, init 0) over the first nbytes of ab, then 1, then op, MSB first.
  function automatic logic [3:0] crc_model(input logic [63:0] ab, input int nbytes,
                                           input logic [2:0] op);
    logic [3:0] c;
    logic       bv, fb;
    c = 4'd0;
    for (int i = 0; i < nbytes * 8 + 4; i++) begin
      if (i < nbytes * 8)       bv = ab[63 - i];
      else if (i == nbytes * 8) bv = 1'b1;
      else                      bv = op[2 - (i - nbytes * 8 - 1)];
      fb = c[3] ^ bv;
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ 4'b0011;
    end
    return c;
  endfunction

  task automatic send_bit(input int p, input logic v);
    @(negedge clk);
    if (p == 0) sin = v;
    else        sin1 = v;
  endtask

  task automatic send_pkt(input int p, input logic typ, input logic [7:0] pay, input logic stop);
    send_bit(p, 1'b0);
    send_bit(p, typ);
    for (int i = 7; i >= 0; i--) send_bit(p, pay[i]);
    send_bit(p, stop);
  endtask

  task automatic send_data(input int p, input logic [63:0] ab, input int n);
    for (int k = 0; k < n; k++) send_pkt(p, 1'b0, ab[63 - 8 * k -: 8], 1'b1);
  endtask

  task automatic send_cmd(input int p, input logic [2:0] op, input logic [3:0] crc);
    send_pkt(p, 1'b1, {1'b0, op, crc}, 1'b1);
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [3:0] err);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.err = err;
    sb.push_back(e);
  endtask

  // Wait (bounded) for a result on instance p and compare it against the scoreboard head.
  task automatic collect(input int p, input string name);
    int n;
    logic v;
    logic [31:0] ga, gb;
    exp_t e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      v = (p == 0) ? valid_o : valid1_o;
    end while (!v && n < 40);
    ga = (p == 0) ? a_o : {24'd0, a1_o};
    gb = (p == 0) ? b_o : {24'd0, b1_o};
    checks++;
    if (!v) begin
      failures++;
      $display("FAIL %s timeout: valid_o got 0 required 1", name);
    end else if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected result: queue empty", name);
    end else begin
      e = sb.pop_front();
      checks += 3;
      if (ga !== e.a) begin
        failures++; $display("FAIL %s a_o: got %h required %h", name, ga, e.a);
      end
      if (gb !== e.b) begin
        failures++; $display("FAIL %s b_o: got %h required %h", name, gb, e.b);
      end
      if (((p == 0) ? op_o : op1_o) !== e.op) begin
        failures++;
        $display("FAIL %s op_o: got %b required %b", name, (p == 0) ? op_o : op1_o, e.op);
      end
      checks++;
      if (((p == 0) ? err_o : err1_o) !== e.err) begin
        failures++;
        $display("FAIL %s err_o: got %b required %b", name, (p == 0) ? err_o : err1_o, e.err);
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({a_o, b_o, op_o, err_o, valid_o} !== 72'd0) begin
      failures++;
      $display("FAIL reset outputs: got %h required 0", {a_o, b_o, op_o, err_o, valid_o});
    end
    checks++;
    if (valid1_o !== 1'b0) begin
      failures++; $display("FAIL reset valid1: got %b required 0", valid1_o);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_zero_frame();
    send_data(0, 64'd0, 8);
    send_cmd(0, 3'b000, 4'hB);
    push_exp(32'd0, 32'd0, 3'b000, 4'b0000);
    collect(0, "zero_frame");
  endtask

  task automatic test_crc_error();
    send_data(0, 64'd0, 8);
    send_cmd(0, 3'b000, 4'hA);
    push_exp(32'd0, 32'd0, 3'b000, CRC_ERR);
    collect(0, "crc_error");
  endtask

  task automatic test_valid_random();
    logic [31:0] a, b;
    logic [2:0] op;
    for (int t = 0; t < 3; t++) begin
      a = $urandom(); b = $urandom();
      op = (t == 0) ? 3'b001 : (t == 1) ? 3'b100 : 3'b101;
      send_data(0, {a, b}, 8);
      send_cmd(0, op, crc_model({a, b}, 8, op));
      push_exp(a, b, op, 4'b0000);
      collect(0, "valid_random");
    end
  endtask

  task automatic test_short_data();
    logic [63:0] ab;
    ab = {$urandom(), $urandom()};
    send_data(0, ab, 6);
    send_cmd(0, 3'b001, crc_model(ab, 6, 3'b001));
    push_exp(32'd0, 32'd0, 3'b001, 4'b0001);
    collect(0, "short_data");
  endtask

  task automatic test_extra_data();
    logic [63:0] ab;
    ab = {$urandom(), $urandom()};
    send_data(0, ab, 8);
    send_pkt(0, 1'b0, 8'h5A, 1'b1);
    send_cmd(0, 3'b100, crc_model(ab, 8, 3'b100));
    push_exp(32'd0, 32'd0, 3'b100, 4'b0001);
    collect(0, "extra_data");
  endtask

  task automatic test_bad_op();
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    send_data(0, {a, b}, 8);
    send_cmd(0, 3'b011, crc_model({a, b}, 8, 3'b011));
    push_exp(a, b, 3'b011, 4'b0100);
    collect(0, "bad_op");
  endtask

  task automatic test_bad_stop();
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    send_data(0, 64'h1122334455667788, 7);
    send_pkt(0, 1'b0, 8'h99, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_data(0, {a, b}, 8);
    send_cmd(0, 3'b101, crc_model({a, b}, 8, 3'b101));
    push_exp(a, b, 3'b101, 4'b0000);
    collect(0, "bad_stop");
  endtask

  task automatic test_overflow();
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom(); b1 = $urandom(); a2 = $urandom(); b2 = $urandom();
    @(negedge clk);
    ready = 1'b0;
    send_data(0, {a1, b1}, 8);
    send_cmd(0, 3'b000, crc_model({a1, b1}, 8, 3'b000));
    push_exp(a1, b1, 3'b000, 4'b1000);
    send_data(0, {a2, b2}, 8);
    send_cmd(0, 3'b001, crc_model({a2, b2}, 8, 3'b001));
    collect(0, "overflow");
    ready = 1'b1;
    @(negedge clk);
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("FAIL overflow release: valid_o got %b required 0", valid_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = $urandom(); b = $urandom();
    send_data(0, 64'hDEADBEEFCAFEF00D, 2);
    send_bit(0, 1'b0);
    send_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    sin = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({a_o, valid_o} !== 33'd0) begin
      failures++; $display("FAIL reset_mid outputs: got %h required 0", {a_o, valid_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
    send_data(0, {a, b}, 8);
    send_cmd(0, 3'b100, crc_model({a, b}, 8, 3'b100));
    push_exp(a, b, 3'b100, 4'b0000);
    collect(0, "reset_mid");
    repeat (3) @(negedge clk);
    checks++;
    if (valid_o !== 1'b0 || sb.size() != 0) begin
      failures++;
      $display("FAIL reset_mid single result: valid_o got %b queue %0d required 0 0",
               valid_o, sb.size());
    end
  endtask

  task automatic test_one_byte();
    logic [7:0] a, b;
    a = 8'($urandom()); b = 8'($urandom());
    send_data(1, {a, b, 48'd0}, 2);
    send_cmd(1, 3'b101, crc_model({a, b, 48'd0}, 2, 3'b101));
    push_exp({24'd0, a}, {24'd0, b}, 3'b101, 4'b0000);
    collect(1, "one_byte");
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_crc_error();
    test_valid_random();
    test_short_data();
    test_extra_data();
    test_bad_op();
    test_bad_stop();
    test_overflow();
    test_reset_mid();
    test_one_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
